divider_mips: RTL

Sequential unsigned 32-by-16 restoring divider for the MIPS datapath. It is the inverse companion of the 16x16 multiplier and produces the quotient and remainder that divide instructions write to the HI/LO path. It accepts one operation on a start strobe, iterates one quotient bit per clock, and flags completion with a one-cycle `validity` pulse. Divide-by-zero and quotient overflow are detected up front and reported without iterating.

---
 rtl/divider_mips_if.sv | 24 ++
 rtl/divider_mips.sv | 108 ++++++++++
 2 files changed

// File: rtl/divider_mips_if.sv
// Operand/result bundle for the sequential MIPS divider.
interface divider_mips_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 validity;
  logic                 busy;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, validity, busy, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, validity, busy, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_mips.sv
// Unsigned 2W-by-W restoring divider, one quotient bit per clock, with
// up-front divide-by-zero and quotient-overflow detection.
module divider_mips #(
  parameter int unsigned WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  divider_mips_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  // Partial remainder kept at W bits: it stays below the divisor, so the
  // extra borrow bit lives only in the trial subtraction below.
  logic [WIDTH-1:0]  p_q;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  dvsr_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  rem_q;
  logic              valid_q;
  logic              busy_q;
  logic              dbz_q;
  logic              ovf_q;

  logic [WIDTH:0]    s;
  logic [WIDTH-1:0]  diff;
  logic              t_ok;
  logic [WIDTH-1:0]  p_next;
  logic [WIDTH-1:0]  q_next;

  always_comb begin
    s      = {p_q, q_q[WIDTH-1]};
    t_ok   = (s >= {1'b0, dvsr_q});
    // True difference is below the divisor, so the low W bits are exact.
    diff   = s[WIDTH-1:0] - dvsr_q;
    p_next = t_ok ? diff : s[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], t_ok};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      p_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            dvsr_q <= bus.divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.divisor == '0 || bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
              dbz_q   <= (bus.divisor == '0);
              ovf_q   <= (bus.divisor != '0);
              quot_q  <= '1;
              rem_q   <= bus.dividend[WIDTH-1:0];
              valid_q <= 1'b1;
              state_q <= StDone;
            end else begin
              dbz_q   <= 1'b0;
              ovf_q   <= 1'b0;
              p_q     <= bus.dividend[2*WIDTH-1:WIDTH];
              q_q     <= bus.dividend[WIDTH-1:0];
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          p_q   <= p_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            quot_q  <= q_next;
            rem_q   <= p_next;
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.validity    = valid_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
